// File: rtl/decode_pkg.sv
// decode_pkg: opcode constants, ALU operation encodings, control-word layout
// and the NOP instruction shared by the decode stage and its register file.
package decode_pkg;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_J     = 6'b000010;

  localparam logic [2:0] ALU_ADD   = 3'b000;
  localparam logic [2:0] ALU_SUB   = 3'b001;
  localparam logic [2:0] ALU_FUNCT = 3'b010;

  localparam int CTRL_W = 10;

  // Bit positions inside the 10-bit control word
  localparam int CTRL_REG_WRITE  = 9;
  localparam int CTRL_MEM_READ   = 8;
  localparam int CTRL_MEM_WRITE  = 7;
  localparam int CTRL_MEM_TO_REG = 6;
  localparam int CTRL_ALU_SRC    = 5;
  localparam int CTRL_REG_DST    = 4;
  localparam int CTRL_BRANCH     = 3;
  localparam int CTRL_ALU_MSB    = 2;
  localparam int CTRL_ALU_LSB    = 0;

  localparam logic [31:0] NOP_INSTR = 32'h0000_0000;

  // Packed so that field order matches the bit positions above
  typedef struct packed {
    logic       reg_write;
    logic       mem_read;
    logic       mem_write;
    logic       mem_to_reg;
    logic       alu_src;
    logic       reg_dst;
    logic       branch;
    logic [2:0] alu_op;
  } ctrl_t;

endpackage

// File: rtl/decode_stage_reg_file.sv
// reg_file: NREGS x W register file, two combinational read ports, one write
// port, r0 hardwired to zero, all entries cleared by rst.
// Optional macro DECODE_BYPASS_EN: a write in the same cycle as a read of the
// same register is forwarded to the read port (write-through).
module reg_file
  import decode_pkg::*;
#(
  parameter int NREGS = 32,
  parameter int W     = 32,
  parameter int AW    = $clog2(NREGS)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic [AW-1:0] ra1_i,
  input  logic [AW-1:0] ra2_i,
  output logic [W-1:0]  rd1_o,
  output logic [W-1:0]  rd2_o,
  input  logic          we_i,
  input  logic [AW-1:0] wa_i,
  input  logic [W-1:0]  wd_i
);

  logic [W-1:0] mem_q [NREGS];

  // Storage: cleared on reset, r0 never written
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < NREGS; i++) mem_q[i] <= '0;
    end else if (we_i && (wa_i != '0)) begin
      mem_q[wa_i] <= wd_i;
    end
  end

  // Read ports: r0 reads as zero, optional same-cycle forwarding of the write
  always_comb begin
    rd1_o = '0;
    rd2_o = '0;
    if (ra1_i != '0) rd1_o = mem_q[ra1_i];
    if (ra2_i != '0) rd2_o = mem_q[ra2_i];
`ifdef DECODE_BYPASS_EN
    if (we_i && (wa_i != '0) && (wa_i == ra1_i)) rd1_o = wd_i;
    if (we_i && (wa_i != '0) && (wa_i == ra2_i)) rd2_o = wd_i;
`else
    // Without forwarding a same-cycle write shows up on the next read.
`endif
  end

endmodule

// File: rtl/decode_stage.sv
// decode_stage: IF/ID register, register-file read, control decode, load-use
// hazard detection, jump resolution and the ID/EX pipeline register.
// Optional macro DECODE_BYPASS_EN enables register-file write-through.
module decode_stage
  import decode_pkg::*;
#(
  parameter int NREGS = 32,
  parameter int W     = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [31:0]       instr_in,
  input  logic [31:0]       pc4_in,
  input  logic              flush,
  input  logic              ex_mem_read,
  input  logic [4:0]        ex_rt,
  input  logic              wb_we,
  input  logic [4:0]        wb_addr,
  input  logic [W-1:0]      wb_data,
  output logic              stall,
  output logic              pc_sel,
  output logic [31:0]       jump_address,
  output logic              idex_valid,
  output logic [W-1:0]      idex_rs_data,
  output logic [W-1:0]      idex_rt_data,
  output logic [W-1:0]      idex_imm,
  output logic [4:0]        idex_rs,
  output logic [4:0]        idex_rt,
  output logic [4:0]        idex_rd,
  output logic [31:0]       idex_pc4,
  output logic [CTRL_W-1:0] idex_ctrl,
  output logic              illegal
);

  logic [31:0] ifid_instr_q, ifid_instr_d;
  logic [31:0] ifid_pc4_q, ifid_pc4_d;
  logic        ifid_valid_q, ifid_valid_d;

  logic          idex_valid_q, idex_valid_d;
  logic [W-1:0]  idex_rs_data_q, idex_rs_data_d;
  logic [W-1:0]  idex_rt_data_q, idex_rt_data_d;
  logic [W-1:0]  idex_imm_q, idex_imm_d;
  logic [4:0]    idex_rs_q, idex_rs_d;
  logic [4:0]    idex_rt_q, idex_rt_d;
  logic [4:0]    idex_rd_q, idex_rd_d;
  logic [31:0]   idex_pc4_q, idex_pc4_d;
  ctrl_t         idex_ctrl_q, idex_ctrl_d;
  logic          illegal_q, illegal_d;

  logic [5:0]   opcode;
  logic [4:0]   rs, rt, rd;
  logic [15:0]  imm16;
  ctrl_t        dec_ctrl;
  logic         dec_illegal;
  logic         uses_rt;
  logic         is_jump;
  logic [W-1:0] rs_data, rt_data;

  assign opcode = ifid_instr_q[31:26];
  assign rs     = ifid_instr_q[25:21];
  assign rt     = ifid_instr_q[20:16];
  assign rd     = ifid_instr_q[15:11];
  assign imm16  = ifid_instr_q[15:0];

  reg_file #(.NREGS(NREGS), .W(W)) u_reg_file (
    .clk   (clk),
    .rst   (rst),
    .ra1_i (rs),
    .ra2_i (rt),
    .rd1_o (rs_data),
    .rd2_o (rt_data),
    .we_i  (wb_we),
    .wa_i  (wb_addr),
    .wd_i  (wb_data)
  );

  // Control decode; J decodes to an all-zero control word but is legal
  always_comb begin
    dec_ctrl    = '0;
    dec_illegal = 1'b0;
    uses_rt     = 1'b0;
    unique case (opcode)
      OP_RTYPE: begin
        dec_ctrl.reg_write = 1'b1;
        dec_ctrl.reg_dst   = 1'b1;
        dec_ctrl.alu_op    = ALU_FUNCT;
        uses_rt            = 1'b1;
      end
      OP_LW: begin
        dec_ctrl.reg_write  = 1'b1;
        dec_ctrl.mem_read   = 1'b1;
        dec_ctrl.mem_to_reg = 1'b1;
        dec_ctrl.alu_src    = 1'b1;
        dec_ctrl.alu_op     = ALU_ADD;
      end
      OP_SW: begin
        dec_ctrl.mem_write = 1'b1;
        dec_ctrl.alu_src   = 1'b1;
        dec_ctrl.alu_op    = ALU_ADD;
        uses_rt            = 1'b1;
      end
      OP_BEQ: begin
        dec_ctrl.branch = 1'b1;
        dec_ctrl.alu_op = ALU_SUB;
        uses_rt         = 1'b1;
      end
      OP_ADDI: begin
        dec_ctrl.reg_write = 1'b1;
        dec_ctrl.alu_src   = 1'b1;
        dec_ctrl.alu_op    = ALU_ADD;
      end
      OP_J:    dec_ctrl = '0;
      default: dec_illegal = 1'b1;
    endcase
  end

  // Hazard and jump outputs are purely combinational from IF/ID and EX
  assign is_jump      = ifid_valid_q && (opcode == OP_J);
  assign pc_sel       = !is_jump;
  assign jump_address = {ifid_pc4_q[31:28], ifid_instr_q[25:0], 2'b00};
  assign stall        = !flush && ifid_valid_q && ex_mem_read && (ex_rt != 5'd0) &&
                        ((ex_rt == rs) || ((ex_rt == rt) && uses_rt));

  // IF/ID next state: flush and jump squash, stall holds, otherwise load
  always_comb begin
    ifid_instr_d = ifid_instr_q;
    ifid_pc4_d   = ifid_pc4_q;
    ifid_valid_d = ifid_valid_q;
    if (flush || is_jump) begin
      ifid_instr_d = NOP_INSTR;
      ifid_pc4_d   = '0;
      ifid_valid_d = 1'b0;
    end else if (!stall) begin
      ifid_instr_d = instr_in;
      ifid_pc4_d   = pc4_in;
      ifid_valid_d = 1'b1;
    end
  end

  // ID/EX next state: bubble unless a valid, unstalled, unflushed instruction
  always_comb begin
    idex_valid_d   = 1'b0;
    idex_rs_data_d = '0;
    idex_rt_data_d = '0;
    idex_imm_d     = '0;
    idex_rs_d      = '0;
    idex_rt_d      = '0;
    idex_rd_d      = '0;
    idex_pc4_d     = '0;
    idex_ctrl_d    = '0;
    illegal_d      = 1'b0;
    if (!flush && !stall && ifid_valid_q) begin
      idex_valid_d   = 1'b1;
      idex_rs_data_d = rs_data;
      idex_rt_data_d = rt_data;
      idex_imm_d     = {{(W-16){imm16[15]}}, imm16};
      idex_rs_d      = rs;
      idex_rt_d      = rt;
      idex_rd_d      = rd;
      idex_pc4_d     = ifid_pc4_q;
      idex_ctrl_d    = dec_ctrl;
      illegal_d      = dec_illegal;
    end
  end

  // IF/ID register
  always_ff @(posedge clk) begin
    if (rst) begin
      ifid_instr_q <= NOP_INSTR;
      ifid_pc4_q   <= '0;
      ifid_valid_q <= 1'b0;
    end else begin
      ifid_instr_q <= ifid_instr_d;
      ifid_pc4_q   <= ifid_pc4_d;
      ifid_valid_q <= ifid_valid_d;
    end
  end

  // ID/EX register
  always_ff @(posedge clk) begin
    if (rst) begin
      idex_valid_q   <= 1'b0;
      idex_rs_data_q <= '0;
      idex_rt_data_q <= '0;
      idex_imm_q     <= '0;
      idex_rs_q      <= '0;
      idex_rt_q      <= '0;
      idex_rd_q      <= '0;
      idex_pc4_q     <= '0;
      idex_ctrl_q    <= '0;
      illegal_q      <= 1'b0;
    end else begin
      idex_valid_q   <= idex_valid_d;
      idex_rs_data_q <= idex_rs_data_d;
      idex_rt_data_q <= idex_rt_data_d;
      idex_imm_q     <= idex_imm_d;
      idex_rs_q      <= idex_rs_d;
      idex_rt_q      <= idex_rt_d;
      idex_rd_q      <= idex_rd_d;
      idex_pc4_q     <= idex_pc4_d;
      idex_ctrl_q    <= idex_ctrl_d;
      illegal_q      <= illegal_d;
    end
  end

  assign idex_valid   = idex_valid_q;
  assign idex_rs_data = idex_rs_data_q;
  assign idex_rt_data = idex_rt_data_q;
  assign idex_imm     = idex_imm_q;
  assign idex_rs      = idex_rs_q;
  assign idex_rt      = idex_rt_q;
  assign idex_rd      = idex_rd_q;
  assign idex_pc4     = idex_pc4_q;
  assign idex_ctrl    = idex_ctrl_q;
  assign illegal      = illegal_q;

endmodule

// File: tb/tb_decode_stage.sv
// tb_decode_stage: directed scenarios plus randomized traffic checked against
// a behavioural model of the decode stage.
module tb_decode_stage;

  logic        clk;
  logic        rst;
  logic [31:0] instr_in, pc4_in;
  logic        flush, ex_mem_read;
  logic [4:0]  ex_rt;
  logic        wb_we;
  logic [4:0]  wb_addr;
  logic [31:0] wb_data;
  logic        stall, pc_sel;
  logic [31:0] jump_address;
  logic        idex_valid;
  logic [31:0] idex_rs_data, idex_rt_data, idex_imm, idex_pc4;
  logic [4:0]  idex_rs, idex_rt, idex_rd;
  logic [9:0]  idex_ctrl;
  logic        illegal;

  int checks = 0;
  int errors = 0;

  decode_stage #(.NREGS(32), .W(32)) dut (
    .clk(clk), .rst(rst), .instr_in(instr_in), .pc4_in(pc4_in), .flush(flush),
    .ex_mem_read(ex_mem_read), .ex_rt(ex_rt), .wb_we(wb_we), .wb_addr(wb_addr),
    .wb_data(wb_data), .stall(stall), .pc_sel(pc_sel), .jump_address(jump_address),
    .idex_valid(idex_valid), .idex_rs_data(idex_rs_data), .idex_rt_data(idex_rt_data),
    .idex_imm(idex_imm), .idex_rs(idex_rs), .idex_rt(idex_rt), .idex_rd(idex_rd),
    .idex_pc4(idex_pc4), .idex_ctrl(idex_ctrl), .illegal(illegal)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL timeout got running exp finished");
    $fatal(1, "timeout");
  end

  // ---------------- behavioural model ----------------
  logic [31:0] m_regs [32];
  logic [31:0] m_if_instr, m_if_pc4;
  logic        m_if_valid;
  logic        m_ex_valid, m_ex_illegal;
  logic [31:0] m_ex_rsd, m_ex_rtd, m_ex_imm, m_ex_pc4;
  logic [4:0]  m_ex_rs, m_ex_rt, m_ex_rd;
  logic [9:0]  m_ex_ctrl;

  // {reg_write, mem_read, mem_write, mem_to_reg, alu_src, reg_dst, branch, alu_op}
  function automatic logic [9:0] ref_ctrl(input logic [5:0] op);
    case (op)
      6'd0:    return 10'b1_0_0_0_0_1_0_010;
      6'd35:   return 10'b1_1_0_1_1_0_0_000;
      6'd43:   return 10'b0_0_1_0_1_0_0_000;
      6'd4:    return 10'b0_0_0_0_0_0_1_001;
      6'd8:    return 10'b1_0_0_0_1_0_0_000;
      default: return 10'b0;
    endcase
  endfunction

  function automatic logic ref_illegal(input logic [5:0] op);
    return !(op == 6'd0 || op == 6'd35 || op == 6'd43 || op == 6'd4 || op == 6'd8 || op == 6'd2);
  endfunction

  function automatic logic ref_stall();
    logic [5:0] op;
    logic [4:0] s, t;
    logic       reads_t;
    op = m_if_instr[31:26];
    s  = m_if_instr[25:21];
    t  = m_if_instr[20:16];
    reads_t = (op == 6'd0 || op == 6'd43 || op == 6'd4);
    return !flush && m_if_valid && ex_mem_read && ex_rt != 0 &&
           (ex_rt == s || (ex_rt == t && reads_t));
  endfunction

  function automatic logic ref_pc_sel();
    return !(m_if_valid && m_if_instr[31:26] == 6'd2);
  endfunction

  function automatic logic [31:0] ref_jaddr();
    return {m_if_pc4[31:28], m_if_instr[25:0], 2'b00};
  endfunction

  function automatic logic [31:0] ref_read(input logic [4:0] a);
    if (a == 0) return 32'h0;
`ifdef DECODE_BYPASS_EN
    if (wb_we && wb_addr == a) return wb_data;
`endif
    return m_regs[a];
  endfunction

  // Advance the model by one clock using the currently driven inputs, then
  // wait for the edge and settle.
  task automatic model_step();
    logic        st, jmp;
    logic [31:0] n_instr, n_pc4;
    logic        n_valid;
    st  = ref_stall();
    jmp = !ref_pc_sel();
    if (rst) begin
      m_ex_valid = 0; m_ex_illegal = 0; m_ex_rsd = 0; m_ex_rtd = 0; m_ex_imm = 0;
      m_ex_pc4 = 0; m_ex_rs = 0; m_ex_rt = 0; m_ex_rd = 0; m_ex_ctrl = 0;
    end else if (flush || st || !m_if_valid) begin
      m_ex_valid = 0; m_ex_illegal = 0; m_ex_rsd = 0; m_ex_rtd = 0; m_ex_imm = 0;
      m_ex_pc4 = 0; m_ex_rs = 0; m_ex_rt = 0; m_ex_rd = 0; m_ex_ctrl = 0;
    end else begin
      m_ex_valid   = 1;
      m_ex_rs      = m_if_instr[25:21];
      m_ex_rt      = m_if_instr[20:16];
      m_ex_rd      = m_if_instr[15:11];
      m_ex_rsd     = ref_read(m_ex_rs);
      m_ex_rtd     = ref_read(m_ex_rt);
      m_ex_imm     = {{16{m_if_instr[15]}}, m_if_instr[15:0]};
      m_ex_pc4     = m_if_pc4;
      m_ex_ctrl    = ref_ctrl(m_if_instr[31:26]);
      m_ex_illegal = ref_illegal(m_if_instr[31:26]);
    end
    if (rst || flush || jmp) begin
      n_instr = 0; n_pc4 = 0; n_valid = 0;
    end else if (st) begin
      n_instr = m_if_instr; n_pc4 = m_if_pc4; n_valid = m_if_valid;
    end else begin
      n_instr = instr_in; n_pc4 = pc4_in; n_valid = 1;
    end
    if (rst) begin
      for (int i = 0; i < 32; i++) m_regs[i] = 0;
    end else if (wb_we && wb_addr != 0) begin
      m_regs[wb_addr] = wb_data;
    end
    @(posedge clk);
    m_if_instr = n_instr;
    m_if_pc4   = n_pc4;
    m_if_valid = n_valid;
    #1;
  endtask

  task automatic drive_idle();
    rst = 0; flush = 0; ex_mem_read = 0; ex_rt = 0;
    wb_we = 0; wb_addr = 0; wb_data = 0;
    instr_in = 32'h0; pc4_in = 32'h0;
  endtask

  task automatic write_reg(input logic [4:0] a, input logic [31:0] d);
    wb_we = 1; wb_addr = a; wb_data = d;
    model_step();
    wb_we = 0;
  endtask

  // ---------------- scenarios ----------------
  task automatic test_reset();
    drive_idle();
    rst = 1; instr_in = 32'h08000040; pc4_in = 32'h1000_0008;
    wb_we = 1; wb_addr = 5; wb_data = 32'h1234_5678;
    model_step();
    model_step();
    drive_idle();
    #1;
    checks++;
    if (idex_valid !== 1'b0 || idex_ctrl !== 10'h0 || illegal !== 1'b0) begin
      errors++; $display("FAIL reset_ctrl got v=%b c=%h i=%b exp 0", idex_valid, idex_ctrl, illegal);
    end
    checks++;
    if ({idex_rs_data, idex_rt_data, idex_imm, idex_pc4} !== 128'h0 ||
        {idex_rs, idex_rt, idex_rd} !== 15'h0) begin
      errors++; $display("FAIL reset_data got %h %h %h %h exp 0", idex_rs_data, idex_rt_data, idex_imm, idex_pc4);
    end
    checks++;
    if (stall !== 1'b0 || pc_sel !== 1'b1 || jump_address !== 32'h0) begin
      errors++; $display("FAIL reset_comb got st=%b ps=%b ja=%h exp 0 1 0", stall, pc_sel, jump_address);
    end
    instr_in = 32'h00A03020;  // add r6,r5,r0
    model_step();
    instr_in = 32'h0;
    model_step();
    checks++;
    if (idex_valid !== 1'b1 || idex_rs_data !== 32'h0) begin
      errors++; $display("FAIL reset_r5 got v=%b d=%h exp 1 0", idex_valid, idex_rs_data);
    end
  endtask

  task automatic test_basic_decode();
    drive_idle();
    write_reg(1, 32'h10);
    write_reg(2, 32'h20);
    instr_in = 32'h00221820; pc4_in = 32'h104;  // add r3,r1,r2
    model_step();
    instr_in = 32'h0; pc4_in = 32'h108;
    model_step();
    checks++;
    if (idex_rs_data !== 32'h10 || idex_rt_data !== 32'h20) begin
      errors++; $display("FAIL add_data got %h %h exp 10 20", idex_rs_data, idex_rt_data);
    end
    checks++;
    if (idex_rd !== 5'd3 || idex_ctrl !== 10'b1000010010 || idex_valid !== 1'b1 || idex_pc4 !== 32'h104) begin
      errors++; $display("FAIL add_ctrl got rd=%0d c=%b v=%b pc4=%h exp 3 1000010010 1 104",
                         idex_rd, idex_ctrl, idex_valid, idex_pc4);
    end
    instr_in = 32'h8C45FFFC;  // lw r5,-4(r2)
    model_step();
    instr_in = 32'hFC000000;  // unknown opcode
    model_step();
    checks++;
    if (idex_ctrl !== 10'b1101100000 || idex_imm !== 32'hFFFF_FFFC || illegal !== 1'b0) begin
      errors++; $display("FAIL lw_ctrl got c=%b imm=%h il=%b exp 1101100000 fffffffc 0", idex_ctrl, idex_imm, illegal);
    end
    instr_in = 32'h0;
    model_step();
    checks++;
    if (idex_ctrl !== 10'h0 || illegal !== 1'b1 || idex_valid !== 1'b1) begin
      errors++; $display("FAIL illegal got c=%b il=%b v=%b exp 0 1 1", idex_ctrl, illegal, idex_valid);
    end
  endtask

  task automatic test_load_use();
    drive_idle();
    instr_in = 32'h00221820;
    model_step();
    instr_in = 32'h0; ex_mem_read = 1; ex_rt = 1;
    #1;
    checks++;
    if (stall !== 1'b1) begin
      errors++; $display("FAIL lu_stall got %b exp 1", stall);
    end
    model_step();
    checks++;
    if (idex_valid !== 1'b0 || idex_ctrl !== 10'h0) begin
      errors++; $display("FAIL lu_bubble got v=%b c=%h exp 0 0", idex_valid, idex_ctrl);
    end
    ex_mem_read = 0; ex_rt = 0;
    #1;
    checks++;
    if (stall !== 1'b0) begin
      errors++; $display("FAIL lu_release got %b exp 0", stall);
    end
    model_step();
    checks++;
    if (idex_valid !== 1'b1 || idex_rs_data !== 32'h10 || idex_rd !== 5'd3) begin
      errors++; $display("FAIL lu_issue got v=%b d=%h rd=%0d exp 1 10 3", idex_valid, idex_rs_data, idex_rd);
    end
  endtask

  task automatic test_jump();
    drive_idle();
    instr_in = 32'h08000040; pc4_in = 32'h1000_0008;
    model_step();
    checks++;
    if (pc_sel !== 1'b0 || jump_address !== 32'h1000_0100) begin
      errors++; $display("FAIL jump_target got ps=%b ja=%h exp 0 10000100", pc_sel, jump_address);
    end
    instr_in = 32'h00221820; pc4_in = 32'h1000_000C;
    model_step();
    checks++;
    if (idex_valid !== 1'b1 || idex_ctrl !== 10'h0 || pc_sel !== 1'b1) begin
      errors++; $display("FAIL jump_bubble got v=%b c=%h ps=%b exp 1 0 1", idex_valid, idex_ctrl, pc_sel);
    end
    instr_in = 32'h0;
    model_step();
    checks++;
    if (idex_valid !== 1'b0) begin
      errors++; $display("FAIL jump_squash got v=%b exp 0", idex_valid);
    end
  endtask

  task automatic test_flush_stall();
    drive_idle();
    instr_in = 32'h00221820;
    model_step();
    flush = 1; ex_mem_read = 1; ex_rt = 2;
    #1;
    checks++;
    if (stall !== 1'b0) begin
      errors++; $display("FAIL flush_stall got %b exp 0", stall);
    end
    model_step();
    checks++;
    if (idex_valid !== 1'b0) begin
      errors++; $display("FAIL flush_idex got v=%b exp 0", idex_valid);
    end
    flush = 0; ex_mem_read = 0; ex_rt = 0;
    model_step();
    checks++;
    if (idex_valid !== 1'b0) begin
      errors++; $display("FAIL flush_ifid got v=%b exp 0", idex_valid);
    end
  endtask

  task automatic test_bypass();
    logic [31:0] exp_rs;
    drive_idle();
    write_reg(4, 32'h1111_1111);
    instr_in = 32'h00802820;  // add r5,r4,r0
    model_step();
    wb_we = 1; wb_addr = 4; wb_data = 32'hDEAD_BEEF;
    model_step();
    wb_we = 0;
`ifdef DECODE_BYPASS_EN
    exp_rs = 32'hDEAD_BEEF;
`else
    exp_rs = 32'h1111_1111;
`endif
    checks++;
    if (idex_rs_data !== exp_rs) begin
      errors++; $display("FAIL bypass_same got %h exp %h", idex_rs_data, exp_rs);
    end
    model_step();
    checks++;
    if (idex_rs_data !== 32'hDEAD_BEEF) begin
      errors++; $display("FAIL bypass_later got %h exp deadbeef", idex_rs_data);
    end
    instr_in = 32'h00002820;  // add r5,r0,r0
    model_step();
    wb_we = 1; wb_addr = 0; wb_data = 32'hFFFF_FFFF;
    model_step();
    checks++;
    if (idex_rs_data !== 32'h0 || idex_rt_data !== 32'h0) begin
      errors++; $display("FAIL r0_same got %h %h exp 0 0", idex_rs_data, idex_rt_data);
    end
    wb_we = 0;
    model_step();
    checks++;
    if (idex_rs_data !== 32'h0) begin
      errors++; $display("FAIL r0_later got %h exp 0", idex_rs_data);
    end
  endtask

  task automatic test_random();
    logic [5:0] ops [7];
    logic [5:0] op;
    ops[0] = 6'd0; ops[1] = 6'd35; ops[2] = 6'd43; ops[3] = 6'd4;
    ops[4] = 6'd8; ops[5] = 6'd2;  ops[6] = 6'd63;
    drive_idle();
    for (int n = 0; n < 400; n++) begin
      op          = ops[$urandom_range(0, 6)];
      instr_in    = {op, 5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)), 16'($urandom)};
      pc4_in      = $urandom;
      rst         = ($urandom_range(0, 99) < 3);
      flush       = ($urandom_range(0, 99) < 8);
      ex_mem_read = ($urandom_range(0, 99) < 35);
      ex_rt       = 5'($urandom_range(0, 7));
      wb_we       = $urandom_range(0, 1);
      wb_addr     = 5'($urandom_range(0, 7));
      wb_data     = $urandom;
      #1;
      checks++;
      if (stall !== ref_stall() || pc_sel !== ref_pc_sel() || jump_address !== ref_jaddr()) begin
        errors++; $display("FAIL rnd_comb[%0d] got st=%b ps=%b ja=%h exp %b %b %h",
                           n, stall, pc_sel, jump_address, ref_stall(), ref_pc_sel(), ref_jaddr());
      end
      model_step();
      checks++;
      if (idex_valid !== m_ex_valid || idex_ctrl !== m_ex_ctrl || illegal !== m_ex_illegal) begin
        errors++; $display("FAIL rnd_ctrl[%0d] got v=%b c=%b il=%b exp %b %b %b",
                           n, idex_valid, idex_ctrl, illegal, m_ex_valid, m_ex_ctrl, m_ex_illegal);
      end
      checks++;
      if (idex_rs_data !== m_ex_rsd || idex_rt_data !== m_ex_rtd || idex_imm !== m_ex_imm ||
          idex_pc4 !== m_ex_pc4 || idex_rs !== m_ex_rs || idex_rt !== m_ex_rt || idex_rd !== m_ex_rd) begin
        errors++; $display("FAIL rnd_data[%0d] got %h %h %h %h exp %h %h %h %h",
                           n, idex_rs_data, idex_rt_data, idex_imm, idex_pc4,
                           m_ex_rsd, m_ex_rtd, m_ex_imm, m_ex_pc4);
      end
    end
    drive_idle();
  endtask

  initial begin
    for (int i = 0; i < 32; i++) m_regs[i] = 0;
    m_if_instr = 0; m_if_pc4 = 0; m_if_valid = 0;
    m_ex_valid = 0; m_ex_illegal = 0; m_ex_rsd = 0; m_ex_rtd = 0; m_ex_imm = 0;
    m_ex_pc4 = 0; m_ex_rs = 0; m_ex_rt = 0; m_ex_rd = 0; m_ex_ctrl = 0;
    drive_idle();
    rst = 1;
    @(negedge clk);
    test_reset();
    test_basic_decode();
    test_load_use();
    test_jump();
    test_flush_stall();
    test_bypass();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
